// File: rtl/array_rw_pkg.sv
// Shared defaults and sizing helpers for the RW0 array client and its response FIFO.
package array_rw_pkg;

  localparam int unsigned DEF_ADDR_W     = 12;
  localparam int unsigned DEF_DATA_W     = 137;
  localparam int unsigned DEF_RESP_DEPTH = 2;
  localparam int unsigned CNT_W          = $clog2(DEF_RESP_DEPTH + 1);

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/array_resp_fifo.sv
// Small circular response FIFO; head entry is read straight out of the storage flops.
module array_resp_fifo
  import array_rw_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned RESP_DEPTH = DEF_RESP_DEPTH,
  localparam int unsigned CW        = cnt_width(RESP_DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CW-1:0]     count
);

  localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic [DATA_W-1:0] mem [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A pop against an empty FIFO is dropped.
  assign do_pop = pop && (count != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !do_pop)      count <= count + CW'(1);
      else if (!push && do_pop) count <= count - CW'(1);
    end
  end

  // Payload storage carries no reset; validity comes from count.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign valid = (count != '0);
  assign data  = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    (push && count == CW'(RESP_DEPTH)) |-> do_pop);

endmodule

// File: rtl/array_rw_client.sv
// Request/response adapter for the single-port RW0 port of a 4096x137 SRAM macro
// with 1-cycle registered read; read credits bound outstanding reads to FIFO depth.
module array_rw_client
  import array_rw_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned RESP_DEPTH = DEF_RESP_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata,
  output logic              rd_inflight
);

  localparam int unsigned CW  = cnt_width(RESP_DEPTH);
  localparam int unsigned CW1 = CW + 1;

  logic [CW-1:0]  count;
  logic [CW1-1:0] committed;
  logic           pop;
  logic           rd_credit;
  logic           rd_fire;

  // Slots already spoken for once this cycle's pop retires; pop implies count >= 1.
  assign pop       = resp_valid && resp_ready;
  assign committed = CW1'(count) + CW1'(rd_inflight) - CW1'(pop);
  assign rd_credit = committed < CW1'(RESP_DEPTH);

  assign req_ready = reset_n && (req_write || rd_credit);
  assign rd_fire   = RW0_en && !req_write;

  assign RW0_en    = req_valid && req_ready;
  assign RW0_wmode = req_write;
  assign RW0_addr  = req_addr;
  assign RW0_wdata = req_wdata;

  // Marks the cycle in which the macro presents data for last cycle's read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rd_inflight <= 1'b0;
    else          rd_inflight <= rd_fire;
  end

  array_resp_fifo #(
    .DATA_W     (DATA_W),
    .RESP_DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rd_inflight),
    .push_data (RW0_rdata),
    .pop       (resp_ready),
    .valid     (resp_valid),
    .data      (resp_data),
    .count     (count)
  );

  a_inflight_origin: assert property (@(posedge clock) disable iff (!reset_n)
    rd_inflight |-> $past(rd_fire));

  a_resp_stable: assert property (@(posedge clock) disable iff (!reset_n)
    (resp_valid && !resp_ready) |=> $stable(resp_data));

endmodule

// File: tb/tb_array_rw_client.sv
// Randomised and directed bench for array_rw_client with a behavioural SRAM macro
// and an in-order expected-response model.
module tb_array_rw_client;
  import array_rw_pkg::*;

  localparam int unsigned AW    = DEF_ADDR_W;
  localparam int unsigned DW    = DEF_DATA_W;
  localparam int unsigned DEPTH = DEF_RESP_DEPTH;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] RW0_addr;
  logic          RW0_en;
  logic          RW0_wmode;
  logic [DW-1:0] RW0_wdata;
  logic [DW-1:0] RW0_rdata;
  logic          rd_inflight;

  array_rw_client dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .RW0_addr    (RW0_addr),
    .RW0_en      (RW0_en),
    .RW0_wmode   (RW0_wmode),
    .RW0_wdata   (RW0_wdata),
    .RW0_rdata   (RW0_rdata),
    .rd_inflight (rd_inflight)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural macro: registered read, rdata holds until the next read.
  logic [DW-1:0] macro_mem [1 << AW];
  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) macro_mem[RW0_addr] <= RW0_wdata;
      else           RW0_rdata <= macro_mem[RW0_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: array contents, expected read data and accept cycle per outstanding read.
  logic [DW-1:0] ref_mem [1 << AW];
  logic [DW-1:0] exp_q [$];
  int            acc_q [$];
  logic          last_rd = 1'b0;
  logic [DW-1:0] resp_log [$];
  int            resp_cyc [$];

  always @(negedge clock) begin
    logic exp_rv;
    logic exp_rd_ok;
    logic rd_acc;
    if (!reset_n) begin
      check("rst_req_ready", DW'(req_ready), DW'(0));
      check("rst_resp_valid", DW'(resp_valid), DW'(0));
      check("rst_rd_inflight", DW'(rd_inflight), DW'(0));
      check("rst_rw0_en", DW'(RW0_en), DW'(0));
      exp_q.delete();
      acc_q.delete();
      last_rd = 1'b0;
    end else begin
      exp_rv    = (acc_q.size() != 0) && (acc_q[0] + 2 <= cyc);
      exp_rd_ok = (acc_q.size() - int'(exp_rv && resp_ready)) < int'(DEPTH);
      check("req_ready", DW'(req_ready), DW'(req_write || exp_rd_ok));
      check("rw0_en", DW'(RW0_en), DW'(req_valid && (req_write || exp_rd_ok)));
      check("rd_inflight", DW'(rd_inflight), DW'(last_rd));
      check("resp_valid", DW'(resp_valid), DW'(exp_rv));
      check("outstanding", DW'(acc_q.size() <= int'(DEPTH)), DW'(1));
      if (resp_valid && exp_rv) check("resp_data", resp_data, exp_q[0]);
      if (resp_valid && resp_ready) begin
        resp_log.push_back(resp_data);
        resp_cyc.push_back(cyc);
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      rd_acc = req_valid && req_ready && !req_write;
      if (req_valid && req_ready && req_write) ref_mem[req_addr] = req_wdata;
      if (rd_acc) begin
        exp_q.push_back(ref_mem[req_addr]);
        acc_q.push_back(cyc);
      end
      last_rd = rd_acc;
    end
  end

  function automatic logic [DW-1:0] rand_data();
    return DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present one request for a single cycle; acc reports whether it was taken.
  task automatic try_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic acc, output int acc_cyc);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clock);
    acc     = req_ready;
    acc_cyc = cyc;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int acc_cyc);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 100) begin
      try_req(w, a, d, acc, acc_cyc);
      tries++;
    end
    if (!acc) check("req_timeout", DW'(acc), DW'(1));
  endtask

  logic [DW-1:0] pre_data [64];
  localparam logic [DW-1:0] BEEF = DW'(64'h1_DEAD_BEEF);

  initial begin
    int   c, prev, base, n_acc, steps;
    logic a0, a1, a2, a3, aw;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    resp_ready = 1'b1;

    // Write then read 0x3A5: single response, 2-cycle latency.
    base = resp_log.size();
    do_req(1'b1, AW'(12'h3A5), BEEF, c);
    idle(1);
    do_req(1'b0, AW'(12'h3A5), '0, c);
    idle(4);
    check("t1_nresp", DW'(resp_log.size() - base), DW'(1));
    if (resp_log.size() > base) begin
      check("t1_data", resp_log[base], BEEF);
      check("t1_latency", DW'(resp_cyc[base] - c), DW'(2));
    end

    // Preload 0..63, then 16 back-to-back reads of 0..15.
    for (int i = 0; i < 64; i++) begin
      pre_data[i] = (i < 16) ? DW'(i * 3) : rand_data();
      do_req(1'b1, AW'(i), pre_data[i], c);
    end
    base = resp_log.size();
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, AW'(i), '0, c);
      if (i > 0) check("t2_b2b_accept", DW'(c - prev), DW'(1));
      prev = c;
    end
    idle(4);
    check("t2_nresp", DW'(resp_log.size() - base), DW'(16));
    for (int i = 0; i < 16 && base + i < resp_log.size(); i++) begin
      check("t2_data", resp_log[base + i], DW'(i * 3));
      if (i > 0) check("t2_resp_gap", DW'(resp_cyc[base + i] - resp_cyc[base + i - 1]), DW'(1));
    end

    // Backpressure: two reads fit, third stalls, writes still pass.
    resp_ready = 1'b0;
    base = resp_log.size();
    try_req(1'b0, AW'(20), '0, a0, c);
    try_req(1'b0, AW'(21), '0, a1, c);
    try_req(1'b0, AW'(22), '0, a2, c);
    pre_data[40] = rand_data();
    try_req(1'b1, AW'(40), pre_data[40], aw, c);
    try_req(1'b0, AW'(22), '0, a3, c);
    check("t3_rd0_acc", DW'(a0), DW'(1));
    check("t3_rd1_acc", DW'(a1), DW'(1));
    check("t3_rd2_stall", DW'(a2), DW'(0));
    check("t3_wr_acc", DW'(aw), DW'(1));
    check("t3_rd2_still", DW'(a3), DW'(0));
    idle(2);
    check("t3_held", DW'(resp_log.size() - base), DW'(0));
    resp_ready = 1'b1;
    do_req(1'b0, AW'(22), '0, c);
    do_req(1'b0, AW'(23), '0, c);
    idle(4);
    check("t3_nresp", DW'(resp_log.size() - base), DW'(4));
    for (int i = 0; i < 4 && base + i < resp_log.size(); i++)
      check("t3_data", resp_log[base + i], pre_data[20 + i]);

    // Read, write same address, read again: old then new.
    do_req(1'b1, AW'(16), DW'(8'h55), c);
    base = resp_log.size();
    try_req(1'b0, AW'(16), '0, a0, c);
    try_req(1'b1, AW'(16), DW'(8'hAA), a1, c);
    try_req(1'b0, AW'(16), '0, a2, c);
    pre_data[16] = DW'(8'hAA);
    check("t4_accepts", DW'({a0, a1, a2}), DW'(3'b111));
    idle(4);
    check("t4_nresp", DW'(resp_log.size() - base), DW'(2));
    if (resp_log.size() >= base + 2) begin
      check("t4_old", resp_log[base], DW'(8'h55));
      check("t4_new", resp_log[base + 1], DW'(8'hAA));
    end

    // Async reset while a read is in flight discards it.
    base = resp_log.size();
    do_req(1'b0, AW'(12'h3A5), '0, c);
    check("t5_inflight_pre", DW'(rd_inflight), DW'(1));
    reset_n = 1'b0;
    #1;
    check("t5_async_resp_valid", DW'(resp_valid), DW'(0));
    check("t5_async_rd_inflight", DW'(rd_inflight), DW'(0));
    check("t5_async_req_ready", DW'(req_ready), DW'(0));
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(5);
    check("t5_no_stale", DW'(resp_log.size() - base), DW'(0));
    do_req(1'b0, AW'(12'h3A5), '0, c);
    idle(4);
    check("t5_nresp", DW'(resp_log.size() - base), DW'(1));
    if (resp_log.size() > base) check("t5_data", resp_log[base], BEEF);

    // Random traffic over addresses 0..63 with random consumer stalls.
    n_acc = 0;
    steps = 0;
    while (n_acc < 10000 && steps < 60000) begin
      resp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) != 0) begin
        try_req($urandom_range(0, 2) == 0, AW'($urandom_range(0, 63)), rand_data(), a0, c);
        n_acc += int'(a0);
      end else begin
        idle(1);
      end
      steps++;
    end
    check("t6_progress", DW'(n_acc >= 10000), DW'(1));
    resp_ready = 1'b1;
    idle(6);
    check("t6_drained", DW'(acc_q.size()), DW'(0));
    check("t6_resp_valid_idle", DW'(resp_valid), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
